lcd_ctrl_block: RTL and testbench



---
 rtl/lcd_ctrl_block_pkg.sv | 51 +++++
 rtl/lcd_view_addr.sv | 16 +
 rtl/lcd_ctrl_block.sv | 156 +++++++++++++++
 tb/tb_lcd_ctrl_block.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_block_pkg.sv
// Shared types and constants for the LCD image controller.
package lcd_ctrl_block_pkg;

  localparam int IMG_W    = 8;
  localparam int VIEW_W   = 4;
  localparam int IMG_PIX  = IMG_W * IMG_W;
  localparam int VIEW_PIX = VIEW_W * VIEW_W;

  localparam logic [2:0] ORIGIN_MAX = 3'd4;
  localparam logic [2:0] ORIGIN_RST = 3'd2;

  typedef enum logic [2:0] {
    RFL  = 3'd0,
    LOAD = 3'd1,
    ZIN  = 3'd2,
    ZFIT = 3'd3,
    SR   = 3'd4,
    SL   = 3'd5,
    SU   = 3'd6,
    SD   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_OUT
  } state_e;

  typedef enum logic {
    MODE_FIT,
    MODE_ZOOM
  } mode_e;

  // Pixel index of view position (r,c). The fit view takes odd rows/cols,
  // which in binary is just {r,1,c,1}. The zoom view offsets by the origin.
  function automatic logic [5:0] view_index(input mode_e      mode,
                                            input logic [2:0] org_x,
                                            input logic [2:0] org_y,
                                            input logic [1:0] r,
                                            input logic [1:0] c);
    logic [2:0] row;
    logic [2:0] col;
    row = org_y + {1'b0, r};
    col = org_x + {1'b0, c};
    if (mode == MODE_FIT) begin
      return {r, 1'b1, c, 1'b1};
    end
    return {row, col};
  endfunction

endpackage

// File: rtl/lcd_view_addr.sv
// Maps the current view mode, window origin and view coordinate to an
// image memory index.
module lcd_view_addr
  import lcd_ctrl_block_pkg::*;
(
  input  mode_e      mode,
  input  logic [2:0] org_x,
  input  logic [2:0] org_y,
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [5:0] pix_idx
);

  assign pix_idx = view_index(mode, org_x, org_y, row, col);

endmodule

// File: rtl/lcd_ctrl_block.sv
// LCD image controller: 8x8 image store, command FSM and 4x4 view streamer.
module lcd_ctrl_block
  import lcd_ctrl_block_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic [7:0] dataout,
  output logic       output_valid,
  output logic       busy
);

  logic [7:0] img [IMG_PIX];

  state_e     state;
  mode_e      mode;
  mode_e      nxt_mode;
  logic [2:0] org_x;
  logic [2:0] org_y;
  logic [2:0] nxt_x;
  logic [2:0] nxt_y;
  logic [3:0] out_cnt;
  logic [5:0] load_cnt;
  logic [3:0] pix_sel;
  logic [5:0] pix_idx;
  logic [7:0] pix_data;
  logic       accept;
  logic       load_last;
  cmd_e       cmd_code;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign cmd_code  = cmd_e'(cmd);
  assign load_last = (state == S_LOAD) && (load_cnt == 6'(IMG_PIX - 1));

  // View state as it will be after this edge, so the first pixel of a
  // command's output can be fetched at the same edge that changes the view.
  always_comb begin
    nxt_mode = mode;
    nxt_x    = org_x;
    nxt_y    = org_y;
    if (accept) begin
      case (cmd_code)
        ZIN: begin
          if (mode == MODE_FIT) begin
            nxt_mode = MODE_ZOOM;
            nxt_x    = ORIGIN_RST;
            nxt_y    = ORIGIN_RST;
          end
        end
        ZFIT: nxt_mode = MODE_FIT;
        SR: if (mode == MODE_ZOOM && org_x < ORIGIN_MAX) nxt_x = org_x + 3'd1;
        SL: if (mode == MODE_ZOOM && org_x != 3'd0)      nxt_x = org_x - 3'd1;
        SD: if (mode == MODE_ZOOM && org_y < ORIGIN_MAX) nxt_y = org_y + 3'd1;
        SU: if (mode == MODE_ZOOM && org_y != 3'd0)      nxt_y = org_y - 3'd1;
        default: ;
      endcase
    end else if (load_last) begin
      nxt_mode = MODE_FIT;
      nxt_x    = ORIGIN_RST;
      nxt_y    = ORIGIN_RST;
    end
  end

  // Position of the pixel registered at this edge: the first one when a
  // stream starts, otherwise the one after the pixel now on dataout.
  always_comb begin
    pix_sel = 4'd0;
    if (state == S_OUT) begin
      pix_sel = out_cnt + 4'd1;
    end
  end

  lcd_view_addr u_view_addr (
    .mode    (nxt_mode),
    .org_x   (nxt_x),
    .org_y   (nxt_y),
    .row     (pix_sel[3:2]),
    .col     (pix_sel[1:0]),
    .pix_idx (pix_idx)
  );

  // Forward the byte being written when it is also the one being read.
  always_comb begin
    pix_data = img[pix_idx];
    if (state == S_LOAD && pix_idx == load_cnt) begin
      pix_data = datain;
    end
  end

  // Image store: one byte per load cycle in raster order; never reset.
  always_ff @(posedge clk) begin
    if (!reset && state == S_LOAD) begin
      img[load_cnt] <= datain;
    end
  end

  // Command FSM with view state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mode         <= MODE_FIT;
      org_x        <= ORIGIN_RST;
      org_y        <= ORIGIN_RST;
      out_cnt      <= 4'd0;
      load_cnt     <= 6'd0;
      busy         <= 1'b0;
      output_valid <= 1'b0;
      dataout      <= 8'd0;
    end else begin
      mode  <= nxt_mode;
      org_x <= nxt_x;
      org_y <= nxt_y;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (cmd_code == LOAD) begin
              state    <= S_LOAD;
              load_cnt <= 6'd0;
            end else begin
              state        <= S_OUT;
              out_cnt      <= 4'd0;
              output_valid <= 1'b1;
              dataout      <= pix_data;
            end
          end
        end
        S_LOAD: begin
          if (load_last) begin
            state        <= S_OUT;
            out_cnt      <= 4'd0;
            output_valid <= 1'b1;
            dataout      <= pix_data;
          end else begin
            load_cnt <= load_cnt + 6'd1;
          end
        end
        S_OUT: begin
          if (out_cnt == 4'(VIEW_PIX - 1)) begin
            state        <= S_IDLE;
            output_valid <= 1'b0;
            busy         <= 1'b0;
            dataout      <= 8'd0;
          end else begin
            out_cnt <= out_cnt + 4'd1;
            dataout <= pix_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_block.sv
// Directed self-checking bench for lcd_ctrl_block.
module tb_lcd_ctrl_block;
  import lcd_ctrl_block_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int checks;
  int failures;

  logic [7:0] fit_tab [16];
  logic [7:0] exp_vals [16];

  lcd_ctrl_block dut (
    .clk          (clk),
    .reset        (reset),
    .datain       (datain),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it, report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic setFit();
    for (int i = 0; i < 16; i++) exp_vals[i] = fit_tab[i];
  endtask

  // Zoom window at origin (x,y) when img[k]=k.
  task automatic setZoom(input int x, input int y);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_vals[r*4 + c] = 8'((y + r) * 8 + x + c);
  endtask

  // Issue one command and follow it until busy drops, checking busy length,
  // output window position/length and (optionally) the 16 pixel values.
  task automatic applyStimulus(input logic [2:0] c, input bit is_load,
                               input bit inject, input bit check_vals,
                               input string tag);
    int cyc;
    int nout;
    int first_ov;
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    cyc      = 0;
    nout     = 0;
    first_ov = -1;
    while (busy && cyc < 200) begin
      if (output_valid) begin
        if (first_ov < 0) first_ov = cyc;
        if (check_vals && nout < 16)
          checkOutput($sformatf("%s_pix%0d", tag, nout), 32'(dataout), 32'(exp_vals[nout]));
        nout++;
      end
      if (is_load && cyc < 64) datain = 8'(cyc);
      else datain = 8'hEE;
      if (inject && cyc == 5) begin
        cmd_valid = 1'b1;
        cmd       = SR;
      end else begin
        cmd_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checkOutput({tag, "_busy_cycles"}, 32'(cyc), is_load ? 32'd80 : 32'd16);
    checkOutput({tag, "_nout"}, 32'(nout), 32'd16);
    checkOutput({tag, "_first_out"}, 32'(first_ov), is_load ? 32'd64 : 32'd0);
    checkOutput({tag, "_valid_after"}, 32'(output_valid), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    fit_tab   = '{8'h09, 8'h0B, 8'h0D, 8'h0F, 8'h19, 8'h1B, 8'h1D, 8'h1F,
                  8'h29, 8'h2B, 8'h2D, 8'h2F, 8'h39, 8'h3B, 8'h3D, 8'h3F};
    reset     = 1'b1;
    datain    = 8'h00;
    cmd       = 3'd0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(output_valid), 32'd0);
    checkOutput("rst_dataout", 32'(dataout), 32'd0);
    reset = 1'b0;

    $display("[TB] load img[k]=k");
    setFit();
    applyStimulus(LOAD, 1'b1, 1'b0, 1'b1, "load");

    $display("[TB] zoom in and pan");
    setZoom(2, 2); applyStimulus(ZIN, 1'b0, 1'b0, 1'b1, "zin");
    setZoom(3, 2); applyStimulus(SR, 1'b0, 1'b0, 1'b1, "sr1");
    setZoom(4, 2); applyStimulus(SR, 1'b0, 1'b0, 1'b1, "sr2");
    setZoom(4, 2); applyStimulus(SR, 1'b0, 1'b0, 1'b1, "sr3_edge");
    setZoom(4, 1); applyStimulus(SU, 1'b0, 1'b0, 1'b1, "su1");
    setZoom(4, 0); applyStimulus(SU, 1'b0, 1'b0, 1'b1, "su2");
    setZoom(4, 0); applyStimulus(SU, 1'b0, 1'b0, 1'b1, "su3_edge");
    setZoom(3, 0); applyStimulus(SL, 1'b0, 1'b0, 1'b1, "sl");
    setZoom(3, 1); applyStimulus(SD, 1'b0, 1'b0, 1'b1, "sd");
    setZoom(3, 1); applyStimulus(ZIN, 1'b0, 1'b0, 1'b1, "zin_again");

    $display("[TB] fit mode commands");
    setFit(); applyStimulus(ZFIT, 1'b0, 1'b0, 1'b1, "zfit");
    setFit(); applyStimulus(SL, 1'b0, 1'b0, 1'b1, "fit_sl");
    setFit(); applyStimulus(SD, 1'b0, 1'b0, 1'b1, "fit_sd");
    setFit(); applyStimulus(RFL, 1'b0, 1'b0, 1'b1, "fit_rfl");
    setZoom(2, 2); applyStimulus(ZIN, 1'b0, 1'b0, 1'b1, "zin_recentre");

    $display("[TB] command strobe while busy");
    setZoom(2, 2); applyStimulus(RFL, 1'b0, 1'b1, 1'b1, "busy_inject");
    setZoom(2, 2); applyStimulus(RFL, 1'b0, 1'b0, 1'b1, "after_inject");

    $display("[TB] reset mid-output");
    setZoom(3, 2); applyStimulus(SR, 1'b0, 1'b0, 1'b1, "pre_rst_sr");
    @(negedge clk);
    cmd       = RFL;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_valid", 32'(output_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(output_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_dataout", 32'(dataout), 32'd0);
    reset = 1'b0;
    applyStimulus(RFL, 1'b0, 1'b0, 1'b0, "post_rst_rfl");
    setZoom(2, 2); applyStimulus(ZIN, 1'b0, 1'b0, 1'b1, "post_rst_zin");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
